// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//
// UART transmitter with an input byte FIFO. Bytes arrive over a valid/ready
// handshake, are queued in a small circular buffer, and are serialised
// LSB-first at CLKS_PER_BIT clock cycles per line bit. Queued frames are sent
// back to back: the next start bit follows the last stop-bit cycle directly.
//
// Build option:
//   UART_TX_PARITY_EN  when defined, an even-parity bit is inserted between
//                      the data bits and the stop bit (8E1, 11-bit frame).
//                      When undefined the frame is 8N1 (10 bits).
//
// Parameters:
//   CLK_FREQ      system clock frequency in Hz
//   BAUD          line rate in bits/s
//   CLKS_PER_BIT  clock cycles per line bit (>= 2)
//   FIFO_DEPTH    FIFO entries (power of two, >= 2)
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   tx_data     byte offered by the producer
//   tx_valid    producer offers tx_data this cycle
//   tx_ready    FIFO has room (registered count != FIFO_DEPTH)
//   tx          serial line, idle high, registered
//   busy        serialiser is not idle
//   fifo_count  bytes queued, not counting the one being shifted out
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLK_FREQ     = 100000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [7:0]                        tx_data,
    input  logic                              tx_valid,
    output logic                              tx_ready,
    output logic                              tx,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  COUNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;

    // Serialiser state
    state_t            state_reg;
    state_t            state_next;
    logic [BAUD_W-1:0] baud_reg;
    logic [BAUD_W-1:0] baud_next;
    logic [2:0]        bit_idx_reg;
    logic [2:0]        bit_idx_next;
    logic [7:0]        shift_reg;
    logic [7:0]        shift_next;
    logic              tx_reg;
    logic              tx_next;

`ifdef UART_TX_PARITY_EN
    // Parity is captured at pop time because the shift register is consumed
    // while the data bits go out.
    logic              parity_reg;
`endif

    logic push;
    logic pop;
    logic baud_end;

    assign tx_ready   = (count_reg != COUNT_FULL);
    assign push       = tx_valid && tx_ready;
    assign baud_end   = (baud_reg == BAUD_LAST);

    assign tx         = tx_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign fifo_count = count_reg;

    // Next-state logic. tx_next is the line level for the state being
    // entered, so the registered tx changes on the same edge as the state.
    always_comb begin
        state_next   = state_reg;
        baud_next    = baud_reg + BAUD_W'(1);
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        tx_next      = tx_reg;
        pop          = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                baud_next = '0;
                tx_next   = 1'b1;
                if (count_reg != '0) begin
                    pop        = 1'b1;
                    tx_next    = 1'b0;
                    state_next = ST_START;
                end
            end

            ST_START: begin
                if (baud_end) begin
                    baud_next    = '0;
                    bit_idx_next = '0;
                    tx_next      = shift_reg[0];
                    state_next   = ST_DATA;
                end
            end

            ST_DATA: begin
                if (baud_end) begin
                    baud_next = '0;
                    if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_next    = parity_reg;
                        state_next = ST_PARITY;
`else
                        tx_next    = 1'b1;
                        state_next = ST_STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                        shift_next   = {1'b0, shift_reg[7:1]};
                        // Bit 1 becomes bit 0 after this shift.
                        tx_next      = shift_reg[1];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_end) begin
                    baud_next  = '0;
                    tx_next    = 1'b1;
                    state_next = ST_STOP;
                end
            end
`endif

            ST_STOP: begin
                if (baud_end) begin
                    baud_next = '0;
                    // Chain straight into the next start bit when more
                    // bytes are waiting, so there is no idle gap.
                    if (count_reg != '0) begin
                        pop        = 1'b1;
                        tx_next    = 1'b0;
                        state_next = ST_START;
                    end else begin
                        tx_next    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end

            default: begin
                baud_next  = '0;
                tx_next    = 1'b1;
                state_next = ST_IDLE;
            end
        endcase
    end

    // Control registers, pointers and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            baud_reg    <= baud_next;
            bit_idx_reg <= bit_idx_next;
            tx_reg      <= tx_next;

            // A pop only happens with a non-empty FIFO, so the entry read
            // here was written on an earlier edge.
            if (pop) begin
                shift_reg  <= mem[rd_ptr_reg];
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
`ifdef UART_TX_PARITY_EN
                parity_reg <= ^mem[rd_ptr_reg];
`endif
            end else begin
                shift_reg  <= shift_next;
            end

            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage array kept free of reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr_reg] <= tx_data;
        end
    end

endmodule
